fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of requester and FIFO write data.
REQ-002 SHALL have parameter BURST_LEN, default 4, maximum beats per grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a write beat.
REQ-006 req0_data  input  DATA_WIDTH  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 beat accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_data, req1_ready  same as REQ-005..007 for requester 1.
REQ-009 fifo_full  input  1  full flag from the shared sync FIFO.
REQ-010 fifo_wr_err  input  1  write-error flag from the shared sync FIFO.
REQ-011 fifo_we  output  1  write enable to the FIFO.
REQ-012 fifo_din  output  DATA_WIDTH  write data to the FIFO.
REQ-013 owner  output  1  requester currently granted; valid only when busy is high.
REQ-014 busy  output  1  high in state BURST.
REQ-015 err_sticky  output  1  latched FIFO write error.

Function
REQ-016 SHALL implement states IDLE and BURST, plus registers owner, last (last served), beat count (4 bits).
REQ-017 IDLE: if exactly one valid is high, SHALL grant it; if both, SHALL grant the requester that is not last; next state BURST, beat count 0; no write in IDLE.
REQ-018 BURST: ready of owner SHALL be combinational: high when busy and not fifo_full; ready of non-owner SHALL be 0.
REQ-019 fifo_we SHALL equal owner valid AND owner ready; fifo_din SHALL be owner's data (0 when fifo_we low).
REQ-020 Each accepted beat SHALL increment beat count by 1.
REQ-021 Burst SHALL end when a beat is accepted with beat count = BURST_LEN-1, or when owner valid is low in BURST.
REQ-022 At burst end last SHALL take owner; re-arbitration SHALL occur in the same edge: other requester valid -> BURST with other owner; else own valid -> BURST same owner; else IDLE; beat count cleared.
REQ-023 fifo_full high SHALL stall the burst without ending it and without incrementing beat count.
REQ-024 Arbiter SHALL never assert fifo_we while fifo_full is high.
REQ-025 err_sticky SHALL set on any cycle fifo_wr_err is high and hold until reset.
REQ-026 Worst-case grant latency for a waiting requester SHALL be BURST_LEN accepted beats of the other plus 1 cycle.

Reset
REQ-027 On rst high, immediately and asynchronously: state IDLE, owner 0, last 1, beat count 0, err_sticky 0; outputs fifo_we 0, fifo_din 0, both ready 0, busy 0.
REQ-028 Reset mid-burst SHALL abandon the burst; no beat SHALL be written in a cycle where rst is high.
REQ-029 After rst falls, requester 0 SHALL win the first contended arbitration.

Configuration
REQ-030 Macro FIFO_WR_ARBITER_STATS_EN defined: SHALL add outputs wr_cnt0 and wr_cnt1, 8 bits each, counting accepted beats per requester, wrapping 255->0, reset to 0.
REQ-031 Macro undefined: SHALL have no counter ports or logic; all other behaviour identical.

Verification
REQ-032 Both valid from reset, FIFO never full, BURST_LEN=4 -> 1 idle cycle, then req0 writes 4 beats, req1 4 beats, req0 4 beats, no gap cycles between bursts.
REQ-033 Only req1 valid, 10 beats -> beats accepted in order 4+4+2 with no gaps, owner stays 1, fifo_din matches req1_data sequence.
REQ-034 req0 owner after 2 beats, fifo_full high 3 cycles -> req0_ready and fifo_we low 3 cycles, beat count held, burst resumes and completes remaining 2 beats.
REQ-035 rst asserted mid-burst (beat 2 of 4) -> fifo_we, busy, readies 0 same cycle; after release with both valid, req0 granted first.
REQ-036 fifo_wr_err pulsed 1 cycle -> err_sticky 1 from next edge until rst; with FIFO_WR_ARBITER_STATS_EN, 260 req0 beats -> wr_cnt0 = 4.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-requester burst arbiter in front of a shared sync FIFO.
// One requester owns the FIFO write port for up to BURST_LEN accepted beats.
// Contended grants alternate between the requesters.
// A write error reported by the FIFO is latched until reset.
// Optional feature: define FIFO_WR_ARBITER_STATS_EN to add per-requester
// 8-bit accepted-beat counters (wr_cnt0 / wr_cnt1).
//
// Handshake: a beat moves on any cycle where reqN_valid and reqN_ready are both
// high. Ready is combinational from the registered state and fifo_full, and it
// never depends on valid. A requester must hold its valid and data stable until
// that beat is accepted.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int BURST_LEN  = 4   // legal range 1..15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  fifo_full,
    input  logic                  fifo_wr_err,
    output logic                  fifo_we,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  owner,
    output logic                  busy,
    output logic                  err_sticky
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [7:0]            wr_cnt0,
    output logic [7:0]            wr_cnt1
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Beat index of the final beat in a burst.
    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;     // requester served most recently
    logic [3:0]            beat_q, beat_d;     // beats accepted in current burst
    logic                  err_q;

    logic                  own_valid;
    logic                  oth_valid;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  own_ready;
    logic                  accept;
    logic                  burst_end;

    // Select the owner's side of the interface and form the write handshake.
    always_comb begin
        own_valid = owner_q ? req1_valid : req0_valid;
        oth_valid = owner_q ? req0_valid : req1_valid;
        own_data  = owner_q ? req1_data  : req0_data;
        own_ready = (state_q == BURST) && !fifo_full;
        accept    = own_valid && own_ready;
        burst_end = (state_q == BURST) &&
                    ((accept && (beat_q == LAST_BEAT)) || !own_valid);
    end

    // Drive ready, write enable, write data and status outputs.
    always_comb begin
        req0_ready = own_ready && !owner_q;
        req1_ready = own_ready && owner_q;
        fifo_we    = accept;
        fifo_din   = accept ? own_data : '0;
        owner      = owner_q;
        busy       = (state_q == BURST);
        err_sticky = err_q;
    end

    // Next-state logic: arbitrate from IDLE, and count beats or re-arbitrate at burst end.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                // No writes happen here; a grant only moves to BURST.
                if (req0_valid && req1_valid) begin
                    owner_d = ~last_q;
                    state_d = BURST;
                    beat_d  = 4'd0;
                end else if (req0_valid) begin
                    owner_d = 1'b0;
                    state_d = BURST;
                    beat_d  = 4'd0;
                end else if (req1_valid) begin
                    owner_d = 1'b1;
                    state_d = BURST;
                    beat_d  = 4'd0;
                end
            end
            BURST: begin
                if (burst_end) begin
                    // Hand over in the same edge so back-to-back bursts have no gap.
                    last_d = owner_q;
                    beat_d = 4'd0;
                    if (oth_valid) begin
                        owner_d = ~owner_q;
                        state_d = BURST;
                    end else if (own_valid) begin
                        state_d = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    beat_d = beat_q + 4'd1;
                end
                // fifo_full without burst_end: stall, nothing changes.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. After reset last=1, so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Sticky FIFO write-error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (fifo_wr_err) begin
            err_q <= 1'b1;
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    // Per-requester accepted-beat counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt0 <= 8'd0;
            wr_cnt1 <= 8'd0;
        end else if (accept) begin
            if (owner_q) begin
                wr_cnt1 <= wr_cnt1 + 8'd1;
            end else begin
                wr_cnt0 <= wr_cnt0 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter.
// Source queues feed the two requesters. Each expected write beat
// {owner, data} is pushed in hand-derived order. A negedge monitor pops and
// compares each beat that the DUT writes.
// With FIFO_WR_ARBITER_STATS_EN defined, the beat counters are also checked.
module tb_fifo_wr_arbiter;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          fifo_full;
  logic          fifo_wr_err;
  logic          fifo_we;
  logic [DW-1:0] fifo_din;
  logic          owner;
  logic          busy;
  logic          err_sticky;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [7:0]    wr_cnt0;
  logic [7:0]    wr_cnt1;
`endif

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_err(fifo_wr_err),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .owner      (owner),
    .busy       (busy),
    .err_sticky (err_sticky)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .wr_cnt0    (wr_cnt0),
    .wr_cnt1    (wr_cnt1)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] src0_q[$];
  logic [DW-1:0] src1_q[$];
  logic [DW:0]   exp_q[$];

  logic s_we, s_busy, s_rdy0, s_owner, s_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic who, input logic [DW-1:0] d);
    exp_q.push_back({who, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    req0_valid = (src0_q.size() != 0);
    req0_data  = (src0_q.size() != 0) ? src0_q[0] : '0;
    req1_valid = (src1_q.size() != 0);
    req1_data  = (src1_q.size() != 0) ? src1_q[0] : '0;
  endtask

  // One clock cycle: sample at negedge, then update the inputs 1 time unit after the posedge.
  task automatic step(input logic full_nx);
    logic a0, a1;
    logic [DW-1:0] tmp;
    @(negedge clk);
    a0      = req0_valid && req0_ready;
    a1      = req1_valid && req1_ready;
    s_we    = fifo_we;
    s_busy  = busy;
    s_rdy0  = req0_ready;
    s_owner = owner;
    s_err   = err_sticky;
    @(posedge clk);
    #1;
    if (a0 && src0_q.size() != 0) tmp = src0_q.pop_front();
    if (a1 && src1_q.size() != 0) tmp = src1_q.pop_front();
    fifo_full = full_nx;
    drive();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    src0_q.delete();
    src1_q.delete();
    fifo_full   = 1'b0;
    fifo_wr_err = 1'b0;
    drive();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0) && n < 600) begin
      step(1'b0);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) step(1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst) begin
      if (fifo_we) begin
        check("we_while_full", fifo_full, 1'b0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got owner=%0d din=0x%0h, required no write", owner, fifo_din);
        end else begin
          e = exp_q.pop_front();
          check("beat_owner_data", {owner, fifo_din}, e);
        end
      end else begin
        check("din_zero_no_we", fifo_din, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst         = 1'b1;
    fifo_full   = 1'b0;
    fifo_wr_err = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check("rst_we", fifo_we, 0);
    check("rst_din", fifo_din, 0);
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_err", err_sticky, 0);

    // Both requesters are valid from reset: one idle cycle, then alternating 4-beat bursts with no gaps.
    for (int i = 0; i < 8; i++) begin
      src0_q.push_back(4'(i));
      src1_q.push_back(4'(i + 8));
    end
    for (int i = 0; i < 4; i++) expect_beat(1'b0, 4'(i));
    for (int i = 0; i < 4; i++) expect_beat(1'b1, 4'(i + 8));
    for (int i = 4; i < 8; i++) expect_beat(1'b0, 4'(i));
    for (int i = 4; i < 8; i++) expect_beat(1'b1, 4'(i + 8));
    release_reset();
    step(1'b0);
    check("t1_idle_we", s_we, 0);
    check("t1_idle_busy", s_busy, 0);
    cnt = 0;
    repeat (16) begin
      step(1'b0);
      if (s_we) cnt++;
    end
    check("t1_no_gap_beats", cnt, 16);
    drain("t1_drain");

    // Only requester 1 is valid, for 10 beats: bursts of 4+4+2, no gaps, owner stays 1.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      src1_q.push_back(4'(i + 3));
      expect_beat(1'b1, 4'(i + 3));
    end
    release_reset();
    step(1'b0);
    cnt = 0;
    repeat (10) begin
      step(1'b0);
      if (s_we && s_owner) cnt++;
    end
    check("t2_owner1_beats", cnt, 10);
    drain("t2_drain");

    // fifo_full stalls after 2 beats: the beat count holds, so the burst is still 4 beats long.
    apply_reset();
    for (int i = 1; i <= 6; i++) src0_q.push_back(4'(i));
    src1_q.push_back(4'd9);
    for (int i = 1; i <= 4; i++) expect_beat(1'b0, 4'(i));
    expect_beat(1'b1, 4'd9);
    expect_beat(1'b0, 4'd5);
    expect_beat(1'b0, 4'd6);
    release_reset();
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("t3_beat2_we", s_we, 1);
    for (int k = 3; k <= 5; k++) begin
      step((k < 5) ? 1'b1 : 1'b0);
      check("t3_stall_we", s_we, 0);
      check("t3_stall_rdy0", s_rdy0, 0);
      check("t3_stall_busy", s_busy, 1);
    end
    step(1'b0);
    check("t3_resume_we", s_we, 1);
    drain("t3_drain");

    // Reset during beat 3 of a burst: outputs go low at once, then requester 0 wins the first tie.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      src0_q.push_back(4'(i + 10));
      src1_q.push_back(4'(i));
    end
    expect_beat(1'b0, 4'd10);
    expect_beat(1'b0, 4'd11);
    release_reset();
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("t4_beat3_presented", fifo_we, 1);
    rst = 1'b1;
    #1;
    check("t4_rst_we", fifo_we, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_rdy0", req0_ready, 0);
    check("t4_rst_rdy1", req1_ready, 0);
    check("t4_written_before_rst", exp_q.size(), 0);
    src0_q.delete();
    src1_q.delete();
    for (int i = 1; i <= 4; i++) begin
      src0_q.push_back(4'(i));
      src1_q.push_back(4'(i + 4));
    end
    for (int i = 1; i <= 4; i++) expect_beat(1'b0, 4'(i));
    for (int i = 5; i <= 8; i++) expect_beat(1'b1, 4'(i));
    drive();
    release_reset();
    step(1'b0);
    step(1'b0);
    check("t4_first_owner", s_owner, 0);
    check("t4_first_we", s_we, 1);
    drain("t4_drain");

    // A one-cycle fifo_wr_err pulse sets err_sticky from the next edge until reset.
    apply_reset();
    release_reset();
    step(1'b0);
    fifo_wr_err = 1'b1;
    step(1'b0);
    check("t5_err_same_cycle", s_err, 0);
    fifo_wr_err = 1'b0;
    step(1'b0);
    check("t5_err_next", s_err, 1);
    repeat (5) step(1'b0);
    check("t5_err_hold", s_err, 1);
    apply_reset();
    #1;
    check("t5_err_cleared", err_sticky, 0);
    release_reset();

`ifdef FIFO_WR_ARBITER_STATS_EN
    // 260 beats from requester 0: the counter wraps to 4.
    for (int i = 0; i < 260; i++) begin
      src0_q.push_back(4'(i));
      expect_beat(1'b0, 4'(i));
    end
    drive();
    drain("t6_drain");
    check("t6_wr_cnt0", wr_cnt0, 4);
    check("t6_wr_cnt1", wr_cnt1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
